demux_4ch: RTL
==============

# demux_4ch

Registered 1-to-4 stream demultiplexer: the receive-side counterpart of the 4:1 data multiplexer. It takes one input stream of DATA_W-bit words, each tagged with a 2-bit channel select, and steers each word into one of four independently back-pressured output channels. A broadcast mode copies a word to all four channels at once. Each channel has a one-deep output register and a saturating delivery counter. The block sits between a shared datapath and four per-channel consumers.

## Interface
- DATA_W, default 4: word width.
- CNT_W, default 8: width of each per-channel delivery counter.

- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept the input word this cycle.
- in_data  input  DATA_W  input word.
- in_sel  input  2  destination channel: 0 = a, 1 = b, 2 = c, 3 = d.
- in_bcast  input  1  send the word to all four channels; in_sel is ignored.
- out_valid  output  4  per-channel valid; bit i = channel i.
- out_ready  input  4  per-channel ready from the consumers.
- out_data  output  4*DATA_W  channel i data at [i*DATA_W +: DATA_W].
- out_count  output  4*CNT_W  channel i count of delivered words at [i*CNT_W +: CNT_W].

## Operation
- **Channel slot.** Each channel i has one register slot, with out_valid[i] as its full flag.
  - A slot is "free" when !out_valid[i] || out_ready[i].
  - This allows pass-through in the same cycle a word drains.
- **Target mask.** The target mask T is 4'b1111 when in_bcast = 1. Otherwise T = one-hot(in_sel).
- **Ready.** in_ready = AND over i of (!T[i] || free[i]).
  - in_ready is combinational from in_sel, in_bcast and out_ready.
  - in_ready does not depend on in_valid.
- **Accept.** An input word is accepted when in_valid && in_ready.
  - On accept, every slot with T[i] = 1 loads in_data and sets out_valid[i].
- **Broadcast is atomic.** It is accepted only when all four slots are free. It never writes a partial subset.
- **Delivery.** Channel i delivers when out_valid[i] && out_ready[i].
  - If the slot is not reloaded in the same cycle, out_valid[i] clears.
  - If the same-cycle accept targets channel i, the slot holds the new word and out_valid[i] stays 1.
- **Holding.** While out_valid[i] = 1 and out_ready[i] = 0, out_data for channel i is held stable.
- **Data of empty slots.** Slots with out_valid[i] = 0 keep their last data, which is don't-care to consumers.
- **Counters.** out_count channel i increments by 1 on each delivery on channel i.
  - Saturates at 2^CNT_W - 1 and never wraps.
  - Counters on different channels update independently in the same cycle.
- **Channel independence.** Unicast words to a free channel are accepted even while other channels are stalled. There is no head-of-line blocking between channels.
- **Illegal input.** None: every in_sel value is legal.
- **Reset values.** Asserting rst_n low at any time, including mid-transfer, immediately clears:
  - out_valid = 0
  - out_data = 0
  - out_count = 0
  - Words held in slots at reset are discarded.
- **in_ready during reset.** With all slots empty, in_ready = 1 for every in_sel and in_bcast value. Nothing is accepted while rst_n = 0.
- **Control FSM per channel.** Two states, EMPTY and FULL.
  - EMPTY → FULL on accept targeting the channel.
  - FULL → EMPTY on delivery without reload.
  - FULL → FULL on delivery with reload, or on stall.

## Timing
- Latency: a word accepted at edge N appears on out_data/out_valid after edge N, i.e. one cycle.
- Throughput: one word per cycle per channel when the consumer holds out_ready = 1.
- Broadcast throughput: one broadcast per cycle only if all four consumers are ready.
- out_count reflects a delivery at edge N after edge N.
- Combinational path: out_ready → in_ready. Upstream must not make in_valid depend on in_ready.

## Structure
- Shared package (demux_pkg):
  - NUM_CH = 4
  - SEL_W = 2
  - channel index constants CH_A..CH_D
  - function sel_to_mask (2-bit select → 4-bit one-hot)
- Natural sub-module: demux_slot, one instance per channel. It contains:
  - data register
  - valid flag
  - free logic
  - saturating CNT_W counter
- The top level holds target-mask decode, the in_ready AND-reduction and the four demux_slot instances.

## Test plan
- **Reset/idle.** Hold rst_n = 0 for 3 cycles.
  - Required: out_valid = 0, out_count = 0, in_ready = 1.
  - After release, with in_valid = 0 for 5 cycles, nothing changes.
- **Unicast sweep.** out_ready = 4'b1111. Send data 0x3, 0x7, 0xA, 0xF with in_sel = 0, 1, 2, 3 on consecutive cycles.
  - Required: each channel shows its word for one cycle, one cycle after accept.
  - Every out_count equals 1.
- **Back-pressure isolation.** out_ready[1] = 0. Send 0x5 to b, then 0x9 to b, then 0xC to d.
  - Required: in_ready drops for the second b word and b holds 0x5.
  - The d word is accepted and delivered. b delivers 0x5 when out_ready[1] rises, then accepts 0x9.
- **Broadcast.** out_ready = 4'b1011 while channel c is full. Issue broadcast 0x6.
  - Required: in_ready = 0 and no channel changes.
  - Once c drains, 0x6 appears on all four channels in the same cycle.
- **Pass-through and saturation.** Keep channel a full with out_ready[0] = 1 and one unicast to a every cycle for 300 cycles.
  - Required: in_ready stays 1 and out_valid[0] stays 1.
  - out_count for a stops at 255.
- **Reset mid-operation.** Fill b and c while stalled, then pulse rst_n low between clock edges.
  - Required: out_valid clears immediately, without waiting for a clock edge.
  - Counters read 0 and no stale word appears after release.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-4 stream demultiplexer: channel count,
// select width, channel indices, the per-slot state type and select decode.
package demux_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    localparam logic [SEL_W-1:0] CH_A = 2'd0;
    localparam logic [SEL_W-1:0] CH_B = 2'd1;
    localparam logic [SEL_W-1:0] CH_C = 2'd2;
    localparam logic [SEL_W-1:0] CH_D = 2'd3;

    // A channel slot is either holding an undelivered word or not.
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // Two-bit channel select to one-hot destination mask.
    function automatic logic [NUM_CH-1:0] sel_to_mask(input logic [SEL_W-1:0] sel);
        logic [NUM_CH-1:0] mask;
        mask = '0;
        case (sel)
            CH_A: mask = 4'b0001;
            CH_B: mask = 4'b0010;
            CH_C: mask = 4'b0100;
            CH_D: mask = 4'b1000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One output channel: a one-deep register slot with its EMPTY/FULL control,
// the "free" indication used by the input handshake, and a saturating
// count of words delivered to the consumer.
module demux_slot
    import demux_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              ready,
    output logic              free,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CNT_W-1:0]  count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    slot_state_e       state_q;
    slot_state_e       state_d;
    logic              deliver;
    logic [DATA_W-1:0] data_q;
    logic [CNT_W-1:0]  count_q;

    assign valid   = (state_q == SLOT_FULL);
    // A full slot whose consumer is ready drains this cycle, so it can take a new word now.
    assign free    = !valid || ready;
    assign deliver = valid && ready;
    assign data    = data_q;
    assign count   = count_q;

    // Slot state register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) state_q <= SLOT_EMPTY;
        else        state_q <= state_d;
    end

    // Next-state: fill on load, empty on delivery unless reloaded in the same cycle.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            SLOT_EMPTY: if (load)             state_d = SLOT_FULL;
            SLOT_FULL:  if (deliver && !load) state_d = SLOT_EMPTY;
        endcase
    end

    // Word register: loads only on accept, otherwise holds (stable under stall).
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the data register is reset because out_data must read zero after reset, not just be "don't care".
        if (!rst_n)    data_q <= '0;
        else if (load) data_q <= load_data;
    end

    // Delivery counter, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                            count_q <= '0;
        else if (deliver && count_q != CNT_MAX) count_q <= count_q + CNT_ONE;
    end

endmodule

// File: rtl/demux_4ch.sv
// Registered 1-to-4 stream demultiplexer. Decodes the destination mask
// (one-hot select or broadcast), accepts a word only when every targeted
// slot is free, and loads all targeted slots together.
module demux_4ch
    import demux_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     in_bcast,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [NUM_CH*CNT_W-1:0]  out_count
);

    logic [NUM_CH-1:0] target;
    logic [NUM_CH-1:0] slot_free;
    logic [NUM_CH-1:0] slot_load;
    logic              accept;

    // Destination mask: all channels for broadcast, else the selected one.
    always_comb begin
        target = in_bcast ? {NUM_CH{1'b1}} : sel_to_mask(in_sel);
    end

    // Every targeted slot must be free; this makes broadcast all-or-nothing
    // while leaving unicast to a free channel unaffected by stalled ones.
    assign in_ready  = &(~target | slot_free);
    assign accept    = in_valid && in_ready;
    assign slot_load = {NUM_CH{accept}} & target;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
        demux_slot #(
            .DATA_W (DATA_W),
            .CNT_W  (CNT_W)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (slot_load[i]),
            .load_data (in_data),
            .ready     (out_ready[i]),
            .free      (slot_free[i]),
            .valid     (out_valid[i]),
            .data      (out_data[i*DATA_W +: DATA_W]),
            .count     (out_count[i*CNT_W +: CNT_W])
        );
    end

endmodule
